// File: rtl/or1200_ic_refill_fsm_pkg.sv
// rtl/or1200_ic_refill_fsm_pkg.sv - state encoding and line geometry helpers for the I-cache refill FSM
package or1200_ic_pkg;

   // Controller states: idle, tag lookup, line burst refill, cache-inhibited single fetch
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      REFILL = 2'd2,
      SINGLE = 2'd3
   } ic_state_e;

   // Byte offset bits below the word index (32-bit words)
   localparam int IC_BYTE_OFF_W = 2;

   // Width of the word index inside a line
   function automatic int ic_off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   // Bytes covered by one cache line
   function automatic int ic_line_bytes(input int line_words);
      return line_words * 4;
   endfunction

endpackage

// File: rtl/or1200_ic_refill_fsm_if.sv
// rtl/or1200_ic_refill_fsm_if.sv - fetch request, tag, bus and RAM-write signals of the refill FSM
interface or1200_ic_refill_fsm_if
   import or1200_ic_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4
);
   localparam int OFF_W = ic_off_w(LINE_WORDS);

   logic              ic_en;
   logic              req_valid;
   logic              req_ci;
   logic [ADDR_W-1:0] req_addr;
   logic              tag_miss;
   logic              biu_valid;
   logic              biu_err;

   logic              biu_read;
   logic              biu_burst;
   logic [ADDR_W-1:0] biu_addr;
   logic              ram_we;
   logic              tag_we;
   logic [OFF_W-1:0]  ram_word;
   logic              hit_ack;
   logic              miss_ack;
   logic              err;
   logic              busy;

   modport master (
      output ic_en, req_valid, req_ci, req_addr, tag_miss, biu_valid, biu_err,
      input  biu_read, biu_burst, biu_addr, ram_we, tag_we, ram_word,
             hit_ack, miss_ack, err, busy
   );

   modport slave (
      input  ic_en, req_valid, req_ci, req_addr, tag_miss, biu_valid, biu_err,
      output biu_read, biu_burst, biu_addr, ram_we, tag_we, ram_word,
             hit_ack, miss_ack, err, busy
   );

endinterface

// File: rtl/or1200_ic_refill_fsm_wrap_ctr.sv
// rtl/or1200_ic_refill_fsm_wrap_ctr.sv - wrapping word pointer and beat counter for one line refill
module or1200_ic_wrap_ctr #(
   parameter int OFF_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [OFF_W-1:0] load_ptr_i,
   input  logic             inc_i,
   output logic [OFF_W-1:0] ptr_o,
   output logic             last_o
);

   logic [OFF_W-1:0] ptr_q, ptr_d;
   logic [OFF_W-1:0] cnt_q, cnt_d;

   // Load restarts a line at the chosen word; each beat advances both, the pointer wrapping in the line
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (load_i) begin
         ptr_d = load_ptr_i;
         cnt_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + OFF_W'(1);
         cnt_d = cnt_q + OFF_W'(1);
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   assign ptr_o  = ptr_q;
   // Line length is a power of two, so the final beat is the all-ones count
   assign last_o = &cnt_q;

endmodule

// File: rtl/or1200_ic_refill_fsm.sv
// rtl/or1200_ic_refill_fsm.sv - I-cache lookup/refill controller; OR1200_IC_CWF_EN selects critical-word-first refill
module or1200_ic_refill_fsm
   import or1200_ic_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   or1200_ic_refill_fsm_if.slave   bus
);

   localparam int OFF_W = ic_off_w(LINE_WORDS);

   ic_state_e               state_q, state_d;
   logic [ADDR_W-1:2]       addr_q, addr_d;
   logic                    ci_q, ci_d;

   logic [OFF_W-1:0]        req_off;
   logic [OFF_W-1:0]        load_ptr;
   logic [OFF_W-1:0]        ptr;
   logic [OFF_W-1:0]        beat_word;
   logic                    ctr_load, ctr_inc, ctr_last;

   logic                    hit_ack, miss_ack, err, ram_we, tag_we;
   logic                    biu_read, biu_burst;

   assign req_off = addr_q[OFF_W+1:2];

`ifdef OR1200_IC_CWF_EN
   assign load_ptr = req_off;
`else
   assign load_ptr = '0;
`endif

   or1200_ic_wrap_ctr #(.OFF_W(OFF_W)) u_wrap_ctr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ctr_load),
      .load_ptr_i (load_ptr),
      .inc_i      (ctr_inc),
      .ptr_o      (ptr),
      .last_o     (ctr_last)
   );

   // Next state and per-cycle strobes; error beats win over data, enable loss discards the beat
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      ci_d      = ci_q;
      ctr_load  = 1'b0;
      ctr_inc   = 1'b0;
      hit_ack   = 1'b0;
      miss_ack  = 1'b0;
      err       = 1'b0;
      ram_we    = 1'b0;
      tag_we    = 1'b0;
      biu_read  = 1'b0;
      biu_burst = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ic_en && bus.req_valid) begin
               addr_d  = bus.req_addr[ADDR_W-1:2];
               ci_d    = bus.req_ci;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (!bus.ic_en || !bus.req_valid) begin
               state_d = IDLE;
            end else if (ci_q) begin
               state_d = SINGLE;
            end else if (!bus.tag_miss) begin
               hit_ack = 1'b1;
               state_d = IDLE;
            end else begin
               ctr_load = 1'b1;
               state_d  = REFILL;
            end
         end
         REFILL: begin
            biu_read  = 1'b1;
            biu_burst = 1'b1;
            if (bus.biu_err) begin
               err     = 1'b1;
               state_d = IDLE;
            end else if (!bus.ic_en) begin
               state_d = IDLE;
            end else if (bus.biu_valid) begin
               ram_we   = 1'b1;
               ctr_inc  = 1'b1;
               miss_ack = (ptr == req_off);
               if (ctr_last) begin
                  tag_we  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         SINGLE: begin
            biu_read = 1'b1;
            if (bus.biu_err) begin
               err     = 1'b1;
               state_d = IDLE;
            end else if (!bus.ic_en) begin
               state_d = IDLE;
            end else if (bus.biu_valid) begin
               miss_ack = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         state_d   = IDLE;
         ctr_load  = 1'b0;
         ctr_inc   = 1'b0;
         hit_ack   = 1'b0;
         miss_ack  = 1'b0;
         err       = 1'b0;
         ram_we    = 1'b0;
         tag_we    = 1'b0;
         biu_read  = 1'b0;
         biu_burst = 1'b0;
      end
   end

   // State and latched request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         ci_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         ci_q    <= ci_d;
      end
   end

   // A burst walks the pointer; a single fetch targets the requested word
   assign beat_word = (state_q == REFILL) ? ptr : req_off;

   assign bus.biu_read  = biu_read;
   assign bus.biu_burst = biu_burst;
   assign bus.biu_addr  = biu_read ? {addr_q[ADDR_W-1:OFF_W+2], beat_word, 2'b00} : '0;
   assign bus.ram_we    = ram_we;
   assign bus.ram_word  = ram_we ? ptr : '0;
   assign bus.tag_we    = tag_we;
   assign bus.hit_ack   = hit_ack;
   assign bus.miss_ack  = miss_ack;
   assign bus.err       = err;
   assign bus.busy      = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_or1200_ic_refill_fsm.sv
// tb/tb_or1200_ic_refill_fsm.sv - self-checking bench for the I-cache refill FSM
module tb_or1200_ic_refill_fsm;

   localparam int LW   = 4;
   localparam int LW_B = 16;
`ifdef OR1200_IC_CWF_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      bit          ci;
      bit          miss;
      bit          withdraw;
      int          err_beat;
      int          abort_beat;
      int          rst_beat;
      int          stalls;
      bit          drop;
      int          exp_hit;
      int          exp_miss;
      int          exp_err;
      int          exp_we;
      int          exp_tag;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   or1200_ic_refill_fsm_if #(.ADDR_W(32), .LINE_WORDS(LW))   ia ();
   or1200_ic_refill_fsm_if #(.ADDR_W(32), .LINE_WORDS(LW_B)) ib ();

   or1200_ic_refill_fsm #(.ADDR_W(32), .LINE_WORDS(LW)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ia.slave)
   );

   or1200_ic_refill_fsm #(.ADDR_W(32), .LINE_WORDS(LW_B)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ib.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int o_hit, o_miss, o_err, o_we, o_tag;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr, input bit ci, input bit miss, input bit wd,
                               input int eb, input int ab, input int rb, input int st, input bit dr,
                               input int eh, input int em, input int ee, input int ew, input int et);
      vec_t v;
      v.addr = addr; v.ci = ci; v.miss = miss; v.withdraw = wd;
      v.err_beat = eb; v.abort_beat = ab; v.rst_beat = rb; v.stalls = st; v.drop = dr;
      v.exp_hit = eh; v.exp_miss = em; v.exp_err = ee; v.exp_we = ew; v.exp_tag = et;
      return v;
   endfunction

   // Word fetched on beat b of a line refill for a request at word offset off
   function automatic int word_at(input int off, input int b, input int lw);
      return CWF ? (off + b) % lw : b;
   endfunction

   // Transaction-level expectation: what a request should produce in total
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int off, nb, stop;
      r = v;
      r.exp_hit = 0; r.exp_miss = 0; r.exp_err = 0; r.exp_we = 0; r.exp_tag = 0;
      off = int'((v.addr >> 2) % LW);
      if (v.withdraw) return r;
      if (!v.ci && !v.miss) begin
         r.exp_hit = 1;
         return r;
      end
      nb   = v.ci ? 1 : LW;
      stop = nb;
      if (v.err_beat >= 0 && v.err_beat < stop) begin
         stop = v.err_beat;
         r.exp_err = 1;
      end
      if (v.abort_beat >= 0 && v.abort_beat < stop) begin
         stop = v.abort_beat;
         r.exp_err = 0;
      end
      for (int b = 0; b < stop; b++) begin
         if (!v.ci) r.exp_we++;
         if (v.ci || word_at(off, b, LW) == off) r.exp_miss++;
      end
      r.exp_tag = (stop == nb && !v.ci) ? 1 : 0;
      return r;
   endfunction

   task automatic inputs_idle_a();
      ia.ic_en = 1'b0; ia.req_valid = 1'b0; ia.req_ci = 1'b0; ia.req_addr = '0;
      ia.tag_miss = 1'b0; ia.biu_valid = 1'b0; ia.biu_err = 1'b0;
   endtask

   task automatic inputs_idle_b();
      ib.ic_en = 1'b0; ib.req_valid = 1'b0; ib.req_ci = 1'b0; ib.req_addr = '0;
      ib.tag_miss = 1'b0; ib.biu_valid = 1'b0; ib.biu_err = 1'b0;
   endtask

   function automatic logic [4:0] flags_a();
      return {ia.hit_ack, ia.miss_ack, ia.err, ia.ram_we, ia.tag_we};
   endfunction

   task automatic observe_a();
      o_hit += int'(ia.hit_ack); o_miss += int'(ia.miss_ack); o_err += int'(ia.err);
      o_we  += int'(ia.ram_we);  o_tag  += int'(ia.tag_we);
   endtask

   // Drive one complete request through DUT A and check every cycle plus the totals
   task automatic run_a(input vec_t v, input string nm);
      int off, nb, w;
      bit is_err, is_abort, is_rst;
      logic [31:0] exp_addr;
      off = int'((v.addr >> 2) % LW);
      nb  = v.ci ? 1 : LW;
      o_hit = 0; o_miss = 0; o_err = 0; o_we = 0; o_tag = 0;

      @(negedge clk);
      ia.ic_en = 1'b1; ia.req_valid = 1'b1; ia.req_addr = v.addr; ia.req_ci = v.ci;
      ia.tag_miss = 1'b0; ia.biu_valid = 1'b0; ia.biu_err = 1'b0;
      #1;
      chk({nm, " idle busy"}, 32'(ia.busy), 32'd0);
      chk({nm, " idle flags"}, 32'(flags_a()), 32'd0);
      observe_a();

      @(negedge clk);
      ia.tag_miss = v.miss;
      ia.req_ci   = 1'b0;
      if (v.withdraw) ia.req_valid = 1'b0;
      #1;
      chk({nm, " lookup busy"}, 32'(ia.busy), 32'd1);
      chk({nm, " lookup biu_read"}, 32'(ia.biu_read), 32'd0);
      chk({nm, " lookup flags"}, 32'(flags_a()),
          (!v.withdraw && !v.ci && !v.miss) ? 32'h10 : 32'h0);
      observe_a();

      if (!v.withdraw && (v.ci || v.miss)) begin
         for (int b = 0; b < nb; b++) begin
            for (int s = 0; s < v.stalls; s++) begin
               @(negedge clk);
               ia.biu_valid = 1'b0; ia.biu_err = 1'b0;
               if (v.drop) ia.req_valid = 1'b0;
               #1;
               chk({nm, " stall flags"}, 32'(flags_a()), 32'd0);
               chk({nm, " stall biu_read"}, 32'(ia.biu_read), 32'd1);
               observe_a();
            end
            is_err   = (b == v.err_beat);
            is_abort = (b == v.abort_beat);
            is_rst   = (b == v.rst_beat);
            @(negedge clk);
            ia.biu_valid = 1'b1;
            ia.biu_err   = is_err;
            ia.ic_en     = !is_abort;
            rst          = is_rst;
            if (v.drop) ia.req_valid = 1'b0;
            #1;
            w = word_at(off, b, LW);
            exp_addr = v.ci ? (v.addr & 32'hFFFF_FFFC)
                            : ((v.addr & ~32'(LW * 4 - 1)) | 32'(w << 2));
            if (is_rst) begin
               chk({nm, " rst flags"}, 32'({flags_a(), ia.biu_read, ia.busy}), 32'd0);
            end else begin
               chk({nm, " beat biu_read"}, 32'(ia.biu_read), 32'd1);
               chk({nm, " beat biu_burst"}, 32'(ia.biu_burst), 32'(!v.ci));
               chk({nm, " beat biu_addr"}, ia.biu_addr, exp_addr);
               if (is_err) begin
                  chk({nm, " err flags"}, 32'(flags_a()), 32'h04);
               end else if (is_abort) begin
                  chk({nm, " abort flags"}, 32'(flags_a()), 32'h00);
               end else begin
                  chk({nm, " ram_we"}, 32'(ia.ram_we), 32'(!v.ci));
                  if (!v.ci) chk({nm, " ram_word"}, 32'(ia.ram_word), 32'(w));
                  chk({nm, " miss_ack"}, 32'(ia.miss_ack), 32'(v.ci || w == off));
                  chk({nm, " tag_we"}, 32'(ia.tag_we), 32'(!v.ci && b == nb - 1));
               end
            end
            observe_a();
            if (is_err || is_abort || is_rst) break;
         end
      end

      @(negedge clk);
      rst = 1'b0;
      inputs_idle_a();
      #1;
      chk({nm, " after busy"}, 32'(ia.busy), 32'd0);
      chk({nm, " after flags"}, 32'(flags_a()), 32'd0);
      chk({nm, " total hit"}, 32'(o_hit), 32'(v.exp_hit));
      chk({nm, " total miss"}, 32'(o_miss), 32'(v.exp_miss));
      chk({nm, " total err"}, 32'(o_err), 32'(v.exp_err));
      chk({nm, " total we"}, 32'(o_we), 32'(v.exp_we));
      chk({nm, " total tag"}, 32'(o_tag), 32'(v.exp_tag));
   endtask

   vec_t tbl[11];
   vec_t rv;
   int   wexp;

   initial begin
      rst = 1'b1;
      inputs_idle_a();
      inputs_idle_b();

      //      addr          ci miss wd  eb  ab  rb st dr  hit miss err we tag
      tbl[0]  = mk(32'h0000_0100, 0, 0, 0, -1, -1, -1, 0, 0, 1, 0, 0, 0, 0);
      tbl[1]  = mk(32'h0000_0104, 0, 0, 0, -1, -1, -1, 0, 0, 1, 0, 0, 0, 0);
      tbl[2]  = mk(32'h0000_0108, 0, 1, 0, -1, -1, -1, 0, 0, 0, 1, 0, 4, 1);
      tbl[3]  = mk(32'h0000_2000, 1, 1, 0, -1, -1, -1, 0, 0, 0, 1, 0, 0, 0);
      tbl[4]  = mk(32'h0000_0100, 0, 1, 0,  1, -1, -1, 0, 0, 0, 1, 1, 1, 0);
      tbl[5]  = mk(32'h0000_0110, 0, 1, 0, -1,  1, -1, 0, 0, 0, 1, 0, 1, 0);
      tbl[6]  = mk(32'h0000_0124, 0, 1, 0, -1, -1,  2, 0, 0, 0, 1, 0, 2, 0);
      tbl[7]  = mk(32'h0000_2004, 1, 0, 0,  0, -1, -1, 0, 0, 0, 0, 1, 0, 0);
      tbl[8]  = mk(32'h0000_0300, 0, 1, 1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0);
      tbl[9]  = mk(32'h0000_3000, 1, 0, 0, -1, -1, -1, 0, 0, 0, 1, 0, 0, 0);
      tbl[10] = mk(32'h0000_040F, 0, 1, 0, -1, -1, -1, 2, 1, 0, 1, 0, 4, 1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset a outs", 32'({flags_a(), ia.biu_read, ia.biu_burst, ia.busy}), 32'd0);
      chk("reset a biu_addr", ia.biu_addr, 32'd0);
      chk("reset b outs", 32'({ib.hit_ack, ib.miss_ack, ib.err, ib.ram_we, ib.tag_we, ib.biu_read, ib.busy}), 32'd0);
      rst = 1'b0;

      // Request while disabled must not leave IDLE
      @(negedge clk);
      ia.req_valid = 1'b1; ia.req_addr = 32'h500; ia.ic_en = 1'b0;
      @(negedge clk);
      #1;
      chk("disabled busy", 32'(ia.busy), 32'd0);
      inputs_idle_a();

      for (int i = 0; i < 11; i++) run_a(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 40; i++) begin
         rv = mk($urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) == 0), -1, -1, -1, $urandom_range(0, 2),
                 ($urandom_range(0, 1) == 1), 0, 0, 0, 0, 0);
         case ($urandom_range(0, 3))
            0: rv.err_beat = $urandom_range(0, LW - 1);
            1: rv.abort_beat = $urandom_range(0, LW - 1);
            default: ;
         endcase
         rv = model(rv);
         run_a(rv, $sformatf("rnd%0d", i));
      end

      // Sixteen-word line requested at its last word: wrap order depends on build
      @(negedge clk);
      ib.ic_en = 1'b1; ib.req_valid = 1'b1; ib.req_addr = 32'h0000_013C;
      @(negedge clk);
      ib.tag_miss = 1'b1;
      #1;
      chk("b16 lookup hit", 32'(ib.hit_ack), 32'd0);
      for (int b = 0; b < LW_B; b++) begin
         @(negedge clk);
         ib.biu_valid = 1'b1;
         #1;
         wexp = CWF ? (15 + b) % LW_B : b;
         chk($sformatf("b16 ram_we%0d", b), 32'(ib.ram_we), 32'd1);
         chk($sformatf("b16 ram_word%0d", b), 32'(ib.ram_word), 32'(wexp));
         chk($sformatf("b16 miss_ack%0d", b), 32'(ib.miss_ack), 32'(wexp == 15));
         chk($sformatf("b16 tag_we%0d", b), 32'(ib.tag_we), 32'(b == LW_B - 1));
      end
      @(negedge clk);
      inputs_idle_b();
      #1;
      chk("b16 after busy", 32'(ib.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
